// File: rtl/vector_dot_arbiter.sv
// Round-robin arbiter that shares one element-wise vector multiply unit among
// NUM_REQ requesters, with a watchdog that aborts and resets a hung unit.
module vector_dot_arbiter #(
    parameter int NUM_REQ           = 2,
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TIMEOUT           = 64
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ*VECTOR_LEN*A_CELL_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*VECTOR_LEN*B_CELL_WIDTH-1:0]    req_b,
    output logic [NUM_REQ-1:0]                            grant,
    output logic [NUM_REQ-1:0]                            done,
    output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]       resp_result,
    output logic                                          resp_error,
    output logic                                          busy,
    output logic                                          dp_start,
    output logic                                          dp_rst,
    output logic [VECTOR_LEN*A_CELL_WIDTH-1:0]            dp_a,
    output logic [VECTOR_LEN*B_CELL_WIDTH-1:0]            dp_b,
    input  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]       dp_result,
    input  logic                                          dp_valid,
    input  logic                                          dp_error
);

    localparam int A_VEC = VECTOR_LEN * A_CELL_WIDTH;
    localparam int B_VEC = VECTOR_LEN * B_CELL_WIDTH;
    localparam int R_VEC = VECTOR_LEN * RESULT_CELL_WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0]   NREQ      = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [PTR_W-1:0]       winner_reg, winner_next;
    logic [WD_W-1:0]        wd_reg, wd_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic [NUM_REQ-1:0]     done_reg, done_next;
    logic [R_VEC-1:0]       resp_result_reg, resp_result_next;
    logic                   resp_error_reg, resp_error_next;
    logic                   busy_reg, busy_next;
    logic                   dp_start_reg, dp_start_next;
    logic                   dp_rst_reg, dp_rst_next;
    logic [A_VEC-1:0]       dp_a_reg, dp_a_next;
    logic [B_VEC-1:0]       dp_b_reg, dp_b_next;

    logic [A_VEC-1:0]       a_slice [NUM_REQ];
    logic [B_VEC-1:0]       b_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*A_VEC +: A_VEC];
            assign b_slice[gi] = req_b[gi*B_VEC +: B_VEC];
        end
    endgenerate

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ.
    logic             arb_found;
    logic [PTR_W-1:0] arb_idx;
    logic [PTR_W:0]   cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!arb_found && req[cand[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PTR_W-1:0];
            end
        end
    end

    logic [WD_W-1:0] wd_inc;
    assign wd_inc = wd_reg + WD_W'(1);

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        winner_next      = winner_reg;
        wd_next          = wd_reg;
        grant_next       = grant_reg;
        done_next        = '0;
        resp_result_next = resp_result_reg;
        resp_error_next  = resp_error_reg;
        dp_start_next    = 1'b0;
        dp_rst_next      = 1'b0;
        dp_a_next        = dp_a_reg;
        dp_b_next        = dp_b_reg;

        case (state_reg)
            S_IDLE: begin
                if (arb_found) begin
                    winner_next          = arb_idx;
                    grant_next           = '0;
                    grant_next[arb_idx]  = 1'b1;
                    dp_a_next            = a_slice[arb_idx];
                    dp_b_next            = b_slice[arb_idx];
                    dp_start_next        = 1'b1;
                    state_next           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_next    = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A valid arriving on the watchdog's last cycle still counts.
                if (dp_valid) begin
                    resp_result_next = dp_result;
                    resp_error_next  = dp_error;
                    done_next        = grant_reg;
                    state_next       = S_DONE;
                end else begin
                    wd_next = wd_inc;
                    if (wd_inc == WD_LIMIT) begin
                        resp_result_next = '0;
                        resp_error_next  = 1'b1;
                        dp_rst_next      = 1'b1;
                        state_next       = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                done_next  = grant_reg;
                state_next = S_DONE;
            end
            S_DONE: begin
                ptr_next   = (winner_reg == LAST_IDX) ? '0 : winner_reg + PTR_W'(1);
                grant_next = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            ptr_reg         <= '0;
            winner_reg      <= '0;
            wd_reg          <= '0;
            grant_reg       <= '0;
            done_reg        <= '0;
            resp_result_reg <= '0;
            resp_error_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            dp_start_reg    <= 1'b0;
            dp_rst_reg      <= 1'b0;
            dp_a_reg        <= '0;
            dp_b_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            winner_reg      <= winner_next;
            wd_reg          <= wd_next;
            grant_reg       <= grant_next;
            done_reg        <= done_next;
            resp_result_reg <= resp_result_next;
            resp_error_reg  <= resp_error_next;
            busy_reg        <= busy_next;
            dp_start_reg    <= dp_start_next;
            dp_rst_reg      <= dp_rst_next;
            dp_a_reg        <= dp_a_next;
            dp_b_reg        <= dp_b_next;
        end
    end

    assign grant       = grant_reg;
    assign done        = done_reg;
    assign resp_result = resp_result_reg;
    assign resp_error  = resp_error_reg;
    assign busy        = busy_reg;
    assign dp_start    = dp_start_reg;
    assign dp_rst      = dp_rst_reg;
    assign dp_a        = dp_a_reg;
    assign dp_b        = dp_b_reg;

endmodule

// File: tb/tb_vector_dot_arbiter.sv
// Randomized bench for vector_dot_arbiter: a latency-programmable unit model and
// a round-robin reference decide the expected winner, timing and response.
module tb_vector_dot_arbiter;

    localparam int N     = 2;
    localparam int VL    = 5;
    localparam int AW    = 8;
    localparam int BW    = 8;
    localparam int RW    = 8;
    localparam int TO    = 8;
    localparam int A_VEC = VL * AW;
    localparam int B_VEC = VL * BW;
    localparam int R_VEC = VL * RW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N*A_VEC-1:0]   req_a = '0;
    logic [N*B_VEC-1:0]   req_b = '0;
    logic [N-1:0]         grant;
    logic [N-1:0]         done;
    logic [R_VEC-1:0]     resp_result;
    logic                 resp_error;
    logic                 busy;
    logic                 dp_start;
    logic                 dp_rst;
    logic [A_VEC-1:0]     dp_a;
    logic [B_VEC-1:0]     dp_b;
    logic [R_VEC-1:0]     dp_result = '0;
    logic                 dp_valid = 1'b0;
    logic                 dp_error = 1'b0;

    vector_dot_arbiter #(
        .NUM_REQ(N), .VECTOR_LEN(VL), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
        .RESULT_CELL_WIDTH(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .grant(grant), .done(done), .resp_result(resp_result),
        .resp_error(resp_error), .busy(busy), .dp_start(dp_start),
        .dp_rst(dp_rst), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
        .dp_valid(dp_valid), .dp_error(dp_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int rr_ptr   = 0;
    int txn      = 0;

    // Unit model: valid rises L cycles after the start cycle; dp_rst clears it.
    int               m_lat = 4;
    bit               m_err = 1'b0;
    int               m_rem = 0;
    bit               m_active = 1'b0;
    logic [R_VEC-1:0] m_result = '0;

    function automatic logic [R_VEC-1:0] rnd_result();
        logic [R_VEC-1:0] v;
        for (int k = 0; k < VL; k++) v[k*RW +: RW] = RW'($urandom);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            m_active = 1'b0;
            m_rem    = 0;
            dp_valid = 1'b0;
            dp_error = 1'b0;
        end else if (dp_rst) begin
            m_active = 1'b0;
            dp_valid = 1'b0;
            dp_error = 1'b0;
        end else if (dp_start) begin
            dp_valid  = 1'b0;
            dp_error  = 1'b0;
            m_rem     = m_lat;
            m_active  = 1'b1;
            m_result  = rnd_result();
            dp_result = rnd_result();
        end else if (m_active) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                dp_valid  = 1'b1;
                dp_error  = m_err;
                dp_result = m_result;
                m_active  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_operands();
        for (int k = 0; k < N*VL; k++) begin
            req_a[k*AW +: AW] = AW'($urandom);
            req_b[k*BW +: BW] = BW'($urandom);
        end
    endtask

    // Called at a negedge with req already set; runs one operation to its done.
    task automatic run_op(input int lat, input bit err, input int start_delay,
                          input bit rand_mid, output int w);
        int               n, t0, t1, rst_cnt;
        bit               gnt_ok, timed_out;
        logic [N-1:0]     exp_gnt;
        logic [A_VEC-1:0] exp_a;
        logic [B_VEC-1:0] exp_b;
        w = pick(req);
        if (w < 0) begin
            check("have_req", 0, 1);
            return;
        end
        exp_gnt    = '0;
        exp_gnt[w] = 1'b1;
        exp_a      = req_a[w*A_VEC +: A_VEC];
        exp_b      = req_b[w*B_VEC +: B_VEC];
        timed_out  = (lat > TO);
        m_lat      = lat;
        m_err      = err;
        t0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dp_start && n < 40);
        check("dp_start", dp_start, 1);
        check("start_delay", cyc - t0, start_delay);
        check("grant_issue", grant, exp_gnt);
        check("dp_a", dp_a, exp_a);
        check("dp_b", dp_b, exp_b);
        check("busy_issue", busy, 1);
        t1      = cyc;
        gnt_ok  = 1'b1;
        rst_cnt = 0;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
            if (grant !== exp_gnt) gnt_ok = 1'b0;
            if (dp_rst) rst_cnt++;
            if (rand_mid && done == '0) begin
                req = N'($urandom);
                rand_operands();
            end
        end while (done == '0 && n < 200);
        check("done", done, exp_gnt);
        check("latency", cyc - t1, timed_out ? TO + 2 : lat + 1);
        check("resp_result", resp_result, timed_out ? '0 : m_result);
        check("resp_error", resp_error, timed_out ? 1'b1 : err);
        check("dp_rst_pulses", rst_cnt, timed_out ? 1 : 0);
        check("grant_stable", gnt_ok, 1);
        check("dp_a_hold", dp_a, exp_a);
        rr_ptr = (w + 1) % N;
        txn++;
        $display("txn %0d: requester %0d lat %0d timeout %0b resp_error %0b done at cycle %0d",
                 txn, w, lat, timed_out, resp_error, cyc);
    endtask

    initial begin
        int w, prev_w, n;
        logic [N-1:0] r;

        // Reset with requests already pending: nothing may leak out.
        req = '1;
        rand_operands();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_dp_rst", dp_rst, 0);
        check("rst_result", resp_result, 0);
        check("rst_error", resp_error, 0);
        check("rst_dp_a", dp_a, 0);

        // Single request, operands 1.0 .. 5.0 in Q4.4.
        rst = 1'b1;
        req = 2'b01;
        for (int k = 0; k < VL; k++) req_a[k*AW +: AW] = AW'((k + 1) << 4);
        run_op(4, 1'b0, 1, 1'b0, w);
        req = '0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
        check("idle_done", done, 0);

        // Both requesting for six operations: strict alternation.
        req = 2'b11;
        rand_operands();
        run_op(3, 1'b0, 1, 1'b0, prev_w);
        for (int i = 0; i < 5; i++) begin
            rand_operands();
            run_op(int'($urandom_range(2, 6)), 1'($urandom), 2, 1'b0, w);
            check("alternate", w, 1 - prev_w);
            prev_w = w;
        end
        req = '0;
        @(negedge clk);

        // Overflow then a clean operation.
        req = 2'b10;
        rand_operands();
        run_op(5, 1'b1, 1, 1'b0, w);
        req = 2'b01;
        run_op(3, 1'b0, 2, 1'b0, w);

        // Valid on the last watchdog cycle wins; one cycle later times out.
        req = 2'b10;
        run_op(TO, 1'b0, 2, 1'b0, w);
        req = 2'b01;
        run_op(1000, 1'b0, 2, 1'b0, w);
        req = '0;
        @(negedge clk);
        check("timeout_busy_after", busy, 0);
        check("timeout_rst_after", dp_rst, 0);

        // Random request patterns, with req and operands churning mid-operation.
        r = N'($urandom_range(1, (1 << N) - 1));
        req = r;
        rand_operands();
        run_op(int'($urandom_range(2, 7)), 1'($urandom), 1, 1'b1, w);
        for (int i = 0; i < 7; i++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            rand_operands();
            run_op(int'($urandom_range(2, 7)), 1'($urandom), 2, 1'b1, w);
        end
        req = '0;
        @(negedge clk);

        // Reset in the middle of WAIT, with the pointer sitting at 1.
        req = 2'b01;
        rand_operands();
        run_op(3, 1'b0, 1, 1'b0, w);
        req = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dp_start && n < 40);
        check("abort_op_start", dp_start, 1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dp_start", dp_start, 0);
        check("midrst_dp_a", dp_a, 0);
        @(negedge clk);
        #2;
        rst    = 1'b1;
        rr_ptr = 0;
        req    = 2'b11;
        run_op(3, 1'b0, 1, 1'b0, w);
        check("post_rst_first", w, 0);
        req = 2'b10;
        run_op(2, 1'b0, 2, 1'b0, w);
        req = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
